// File: rtl/bus_mem_responder.sv
// Word-addressed RAM on the responder side of the generic bus,
// with a programmable number of wait states per transaction.
module bus_mem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t          r_state;
  logic [3:0]      r_count;
  logic            r_op_wr;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_done;
  logic            w_unused_addr;

  assign w_req         = ren | wen;
  assign w_done        = (r_state == WAIT) && (r_count == 4'd0) && w_req;
  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};

  assign busy  = ~w_done;
  assign rdata = (w_done && !r_op_wr) ? r_mem[r_idx] : 32'h0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= WAIT;
            r_op_wr <= wen;
            r_idx   <= addr[AW+1:2];
            r_wdata <= wdata;
            r_be    <= byte_en;
            r_count <= 4'(LATENCY);
          end
        end
        WAIT: begin
          // Requester withdrawing the request aborts without a write.
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST && w_done && r_op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed and randomized checks of bus_mem_responder against
// a word-array reference model kept in the bench.
module tb_bus_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ren, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  logic        ren0, wen0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic [31:0] rdata0;
  logic        busy0;

  int nchk  = 0;
  int npass = 0;

  logic [31:0] m [1024];
  bit          v [1024];

  always #5 CLK = ~CLK;

  bus_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen),
    .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .rdata(rdata), .busy(busy)
  );

  bus_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .ren(ren0), .wen(wen0),
    .addr(addr0), .wdata(wdata0), .byte_en(be0),
    .rdata(rdata0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Called one time unit after a rising edge with the DUT idle.
  task automatic xact(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output int lat);
    wen = w; ren = r; addr = a; wdata = d; byte_en = be;
    lat = 0; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        addr = $urandom; wdata = $urandom; byte_en = 4'($urandom);
      end
      if (!busy) begin
        lat = k; rd = rdata; break;
      end
    end
    @(posedge CLK); #1;
    ren = 0; wen = 0;
    check("busy_after_done", {31'b0, busy}, 32'd1);
  endtask

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit both);
    logic [31:0] rd;
    int lat;
    xact(1'b1, both, a, d, be, rd, lat);
    check("wr_latency", lat, 32'd3);
    check("wr_rdata_zero", rd, 32'h0);
    m[widx(a)] = merge(m[widx(a)], d, be);
    v[widx(a)] = 1'b1;
  endtask

  task automatic mread(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    xact(1'b0, 1'b1, a, 32'h0, 4'h0, rd, lat);
    check("rd_latency", lat, 32'd3);
    check(tag, rd, exp);
  endtask

  initial begin
    nRST = 0; ren = 0; wen = 0; addr = 0; wdata = 0; byte_en = 0;
    ren0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
    for (int i = 0; i < 1024; i++) v[i] = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy0", {31'b0, busy0}, 32'd1);
    nRST = 1;
    @(posedge CLK); #1;

    mwrite(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
    mread("t1_read", 32'h40, 32'hDEADBEEF);

    mwrite(32'h80, 32'h11223344, 4'hF, 1'b0);
    mwrite(32'h80, 32'hAABBCCDD, 4'b0101, 1'b0);
    mread("t2_lanes", 32'h80, 32'h11BB33DD);

    // Abort: withdraw a write before it completes.
    mwrite(32'h10, 32'h5, 4'hF, 1'b0);
    wen = 1; addr = 32'h10; wdata = 32'h99; byte_en = 4'hF;
    @(posedge CLK); #1;
    check("t4_wait_busy", {31'b0, busy}, 32'd1);
    wen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      check("t4_abort_busy", {31'b0, busy}, 32'd1);
    end
    mread("t4_read", 32'h10, 32'h5);

    mwrite(32'h1004, 32'h1234, 4'hF, 1'b1);
    mread("t5_wrap", 32'h4, 32'h1234);

    // Reset during the wait of a write.
    mwrite(32'h20, 32'h77, 4'hF, 1'b0);
    wen = 1; addr = 32'h20; wdata = 32'hABCD; byte_en = 4'hF;
    @(posedge CLK); #1;
    nRST = 0;
    @(posedge CLK); #1;
    check("t6_rst_busy", {31'b0, busy}, 32'd1);
    check("t6_rst_rdata", rdata, 32'h0);
    nRST = 1; wen = 0;
    @(posedge CLK); #1;
    mread("t6_mem_kept", 32'h20, 32'h77);
    mwrite(32'h20, 32'hCAFE, 4'hF, 1'b0);
    mread("t6_after_rst", 32'h20, 32'hCAFE);

    // Zero wait states on the second instance.
    wen0 = 1; addr0 = 32'h8; wdata0 = 32'h0BADF00D; be0 = 4'hF;
    @(posedge CLK); #1;
    check("t3_wr_busy", {31'b0, busy0}, 32'd0);
    @(posedge CLK); #1;
    wen0 = 0;
    check("t3_wr_idle", {31'b0, busy0}, 32'd1);
    ren0 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      check("t3_b2b_busy", {31'b0, busy0}, (k % 2 == 1) ? 32'd0 : 32'd1);
      if (k % 2 == 1) check("t3_b2b_rdata", rdata0, 32'h0BADF00D);
    end
    ren0 = 0;

    // Random traffic over 16 words with aliasing upper address bits.
    for (int n = 0; n < 150; n++) begin
      int idx;
      logic [31:0] a;
      idx = int'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFF_F000) | (idx << 2) | ($urandom & 3);
      if (!v[idx]) begin
        mwrite(a, $urandom, 4'hF, 1'b0);
      end else if ($urandom_range(0, 1) == 0) begin
        mwrite(a, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
      end else begin
        mread("rand_read", a, m[idx]);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
